fifo_fwft: RTL
==============

# fifo_fwft

Parametrised synchronous first-word-fall-through FIFO; successor to the single-flag merge-stage FIFO. Adds full/almost flags, an occupancy count, a flush, guarded pointers, and sticky overflow/underflow error flags. Sits between the sorter merge stages, where the consumer compares heads (`dout`) before popping. One clock domain, storage in a register array.

## Interface
Parameters:
- `DATA_WIDTH`, 32, word width in bits.
- `LOG2_DEPTH`, 2, log2 of depth; DEPTH = 2**LOG2_DEPTH; legal 1..10.
- `AF_THRESH`, DEPTH-1, `almost_full` asserts when count >= AF_THRESH; legal 1..DEPTH.
- `AE_THRESH`, 1, `almost_empty` asserts when count <= AE_THRESH; legal 0..DEPTH-1.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `din`  in  DATA_WIDTH  write data.
- `wr_en`  in  1  push request.
- `rd_en`  in  1  pop request.
- `flush`  in  1  synchronous clear of contents; error flags are kept.
- `dout`  out  DATA_WIDTH  head word; valid while `empty`=0; 0 while `empty`=1.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count >= AF_THRESH.
- `almost_empty`  out  1  count <= AE_THRESH.
- `count`  out  LOG2_DEPTH+1  occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a push was rejected.
- `underflow`  out  1  sticky: a pop was rejected.

## Operation
- State: `wr_ptr` and `rd_ptr` (LOG2_DEPTH bits each, natural wrap modulo DEPTH), `count` register, storage array, `overflow` and `underflow` registers.
- rd_acc = `rd_en` & !`empty`.
- wr_acc = `wr_en` & (!`full` | rd_acc).
  - When full, a push is accepted only together with an accepted pop in the same cycle.
- Accepted push: mem[wr_ptr] <= din; wr_ptr++.
- Accepted pop: rd_ptr++. Rejected requests do not move pointers, change count, or write memory.
- Count update:
  - +1 on wr_acc & !rd_acc.
  - -1 on rd_acc & !wr_acc.
  - Unchanged when both or neither are accepted.
- Push and pop on a non-empty, non-full FIFO: both are performed and count is unchanged.
- Push and pop on an empty FIFO: push is accepted, pop is rejected, and `underflow` is set.
- Push and pop on a full FIFO: both are accepted and count stays at DEPTH.
- `overflow` <= 1 when `wr_en` & !wr_acc. `underflow` <= 1 when `rd_en` & `empty`. Both are cleared only by `reset`.
- Flush:
  - Sets pointers and count to 0.
  - Has priority over `wr_en` and `rd_en` in the same cycle; those requests are discarded and do not set error flags.
  - Memory contents are not cleared.
- Reset:
  - Has priority over flush and all requests.
  - Clears pointers, count, `overflow` and `underflow`.
  - Reset mid-operation discards all contents.
- Outputs after reset: `dout`=0, `full`=0, `empty`=1, `almost_full`=0 (AF_THRESH>=1), `almost_empty`=1, `count`=0, `overflow`=0, `underflow`=0.
- `full`, `empty`, `almost_*` and `dout` are combinational decodes of registered state only. There is no input-to-output combinational path.

## Timing
- Write-to-read latency is 1 cycle. A word pushed at edge N appears on `dout` and `empty` falls after edge N.
- `dout` always shows mem[rd_ptr] while non-empty (FWFT). After a pop at edge N, the next word (or 0 if now empty) is shown after edge N.
- All flags and `count` change only after a clock edge, in the same cycle as each other.
- Back-to-back push+pop every cycle sustains 1 word/cycle at any occupancy, including full.
- Flush or reset at edge N: `empty`=1 and `count`=0 after edge N.

## Test plan
- Reset, then idle: `empty`=1, `almost_empty`=1, `count`=0, `dout`=0, `full`=0, both error flags 0.
- DEPTH=4, AF_THRESH=3, AE_THRESH=1. Push 0xA0..0xA3 on 4 consecutive cycles:
  - `count` steps 1,2,3,4.
  - `almost_empty` drops when `count` reaches 2.
  - `almost_full` rises at 3; `full` rises at 4.
  - `dout`=0xA0 from the cycle after the first push.
- With the FIFO full, push 0xFF alone: rejected, `overflow`=1, `count` stays 4. Then pop 4 times: `dout` sequence 0xA0,0xA1,0xA2,0xA3, then `empty`=1 and `dout`=0.
- Simultaneous push+pop at full, then 8 cycles of continuous push+pop with incrementing data:
  - `count` stays 4.
  - Pointers wrap and output order is preserved.
  - No error flags are set.
- On an empty FIFO, assert `rd_en`+`wr_en` with din=0x55: `underflow`=1, `count`=1, `dout`=0x55 next cycle.
- Push 3 words, then assert `flush` together with `wr_en`: `count`=0 and `empty`=1 next cycle, and no `overflow`. Then reset: `underflow` and `overflow` clear to 0.

Source files
------------

// File: rtl/fifo_fwft_if.sv
// fifo_fwft_if: push/pop handshake, head data and status flags of the FWFT FIFO
interface fifo_fwft_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LOG2_DEPTH = 2
);
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  wr_en;
  logic                  rd_en;
  logic                  flush;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [LOG2_DEPTH:0]   count;
  logic                  overflow;
  logic                  underflow;
  modport master (
    output din, wr_en, rd_en, flush,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  din, wr_en, rd_en, flush,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_fwft.sv
// fifo_fwft: synchronous first-word-fall-through FIFO with count, threshold flags,
// flush and sticky overflow/underflow flags
module fifo_fwft #(
  parameter int DATA_WIDTH = 32,
  parameter int LOG2_DEPTH = 2,
  parameter int AF_THRESH  = (1 << LOG2_DEPTH) - 1,
  parameter int AE_THRESH  = 1
) (
  input logic        clk,
  input logic        reset,
  fifo_fwft_if.slave bus
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] DEPTH_C = (LOG2_DEPTH+1)'(DEPTH);
  localparam logic [LOG2_DEPTH:0] AF_C    = (LOG2_DEPTH+1)'(AF_THRESH);
  localparam logic [LOG2_DEPTH:0] AE_C    = (LOG2_DEPTH+1)'(AE_THRESH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [LOG2_DEPTH:0]   cnt;
  logic                  ovf, udf, empty, full, rd_acc, wr_acc;
  always_comb begin
    empty  = cnt == '0;
    full   = cnt == DEPTH_C;
    rd_acc = bus.rd_en & ~empty;
    wr_acc = bus.wr_en & (~full | rd_acc);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      cnt <= (wr_acc && !rd_acc) ? cnt + 1'b1 : (rd_acc && !wr_acc) ? cnt - 1'b1 : cnt;
      if (bus.wr_en && !wr_acc) ovf <= 1'b1;
      if (bus.rd_en && empty) udf <= 1'b1;
    end
  end
  // storage is never cleared; count alone decides which words are live
  always_ff @(posedge clk) begin
    if (!reset && !bus.flush && wr_acc) mem[wr_ptr] <= bus.din;
  end
  assign bus.dout         = empty ? '0 : mem[rd_ptr];
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = cnt >= AF_C;
  assign bus.almost_empty = cnt <= AE_C;
  assign bus.count        = cnt;
  assign bus.overflow     = ovf;
  assign bus.underflow    = udf;
endmodule
